// File: rtl/axis_stream_receiver_if.sv
// AXI-Stream bus bundle for the receiver's upstream side.
// The master modport is the transmitter, the slave modport is the receiver.
interface axis_stream_receiver_if #(
  parameter int DATA_WIDTH = 16,
  parameter int USER_WIDTH = 2,
  parameter int DEST_WIDTH = 8
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic                  S_TVALID;
  logic                  S_TREADY;
  logic [DATA_WIDTH-1:0] S_TDATA;
  logic [KEEP_WIDTH-1:0] S_TKEEP;
  logic                  S_TLAST;
  logic [USER_WIDTH-1:0] S_TUSER;
  logic                  S_TID;
  logic [DEST_WIDTH-1:0] S_TDEST;

  modport master (
    output S_TVALID, S_TDATA, S_TKEEP, S_TLAST, S_TUSER, S_TID, S_TDEST,
    input  S_TREADY
  );

  modport slave (
    input  S_TVALID, S_TDATA, S_TKEEP, S_TLAST, S_TUSER, S_TID, S_TDEST,
    output S_TREADY
  );
endinterface

// File: rtl/axis_stream_receiver.sv
// AXI-Stream slave endpoint: 2-entry skid FIFO towards a valid/ready output
// port, plus a packet framer that truncates packets longer than MAX_BEATS and
// reports per-packet beat count and truncation status.
//
// Optional feature macro: AXIS_RX_KEEP_MASK_EN
//   defined   - byte lanes with TKEEP=0 are zeroed; all-zero TKEEP beats are
//               accepted but neither stored nor counted.
//   undefined - TKEEP is ignored.
//
// state  | meaning
// IDLE   | between packets, next forwarded beat starts a packet
// IN_PKT | inside a packet, bcnt beats forwarded so far
// DROP   | packet hit MAX_BEATS, swallowing beats until TLAST
module axis_stream_receiver #(
  parameter int DATA_WIDTH = 16,
  parameter int USER_WIDTH = 2,
  parameter int DEST_WIDTH = 8,
  parameter int MAX_BEATS  = 256,
  parameter int CNT_WIDTH  = $clog2(MAX_BEATS + 1)
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  axis_stream_receiver_if.slave s_axis,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [USER_WIDTH-1:0] out_user,
  output logic                  out_id,
  output logic [DEST_WIDTH-1:0] out_dest,
  output logic                  pkt_done,
  output logic [CNT_WIDTH-1:0]  pkt_beats,
  output logic                  pkt_err,
  output logic [1:0]            rx_state
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IN_PKT = 2'd1;
  localparam logic [1:0] DROP   = 2'd2;

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_BEATS);
  localparam logic [CNT_WIDTH-1:0] ONE_CNT = CNT_WIDTH'(1);

  logic [1:0]            state, state_nxt;
  logic [CNT_WIDTH-1:0]  bcnt, bcnt_nxt, bcnt_inc;
  logic                  done_nxt, err_nxt;
  logic [CNT_WIDTH-1:0]  beats_nxt;

  logic [DATA_WIDTH-1:0] mem_data [2];
  logic                  mem_last [2];
  logic [USER_WIDTH-1:0] mem_user [2];
  logic                  mem_id   [2];
  logic [DEST_WIDTH-1:0] mem_dest [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            count;

  logic                  accept, pop, push, push_last, is_null;
  logic [DATA_WIDTH-1:0] push_data;

  // DROP always accepts so the upstream can flush the oversize tail.
  assign s_axis.S_TREADY = ARESETn && ((state == DROP) || (count != 2'd2));
  assign accept          = s_axis.S_TVALID && s_axis.S_TREADY;
  assign out_valid       = (count != 2'd0);
  assign pop             = out_valid && out_ready;
  assign bcnt_inc        = bcnt + ONE_CNT;
  assign rx_state        = state;

  assign out_data = mem_data[rd_ptr];
  assign out_last = mem_last[rd_ptr];
  assign out_user = mem_user[rd_ptr];
  assign out_id   = mem_id[rd_ptr];
  assign out_dest = mem_dest[rd_ptr];

`ifdef AXIS_RX_KEEP_MASK_EN
  // Zero the byte lanes the transmitter marked as not kept.
  always_comb begin
    push_data = s_axis.S_TDATA;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      if (!s_axis.S_TKEEP[i]) push_data[i*8 +: 8] = 8'h00;
    end
  end
  assign is_null = ~|s_axis.S_TKEEP;
`else
  logic keep_unused;
  assign keep_unused = ^s_axis.S_TKEEP;
  assign push_data   = s_axis.S_TDATA;
  assign is_null     = 1'b0;
`endif

  // Framer: decide push, forced last, next state and packet status.
  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    push      = 1'b0;
    push_last = s_axis.S_TLAST;
    done_nxt  = 1'b0;
    beats_nxt = pkt_beats;
    err_nxt   = pkt_err;
    case (state)
      IDLE, IN_PKT: begin
        if (accept) begin
          if (is_null) begin
            // A null terminator closes the packet but its last marker is lost.
            if (s_axis.S_TLAST) begin
              done_nxt  = 1'b1;
              beats_nxt = bcnt;
              err_nxt   = 1'b1;
              bcnt_nxt  = '0;
              state_nxt = IDLE;
            end
          end else begin
            push = 1'b1;
            if (s_axis.S_TLAST) begin
              done_nxt  = 1'b1;
              beats_nxt = bcnt_inc;
              err_nxt   = 1'b0;
              bcnt_nxt  = '0;
              state_nxt = IDLE;
            end else if (bcnt_inc == MAX_CNT) begin
              push_last = 1'b1;
              bcnt_nxt  = bcnt_inc;
              state_nxt = DROP;
            end else begin
              bcnt_nxt  = bcnt_inc;
              state_nxt = IN_PKT;
            end
          end
        end
      end
      DROP: begin
        if (accept && s_axis.S_TLAST) begin
          done_nxt  = 1'b1;
          beats_nxt = MAX_CNT;
          err_nxt   = 1'b1;
          bcnt_nxt  = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        bcnt_nxt  = '0;
      end
    endcase
  end

  // Framer state, beat counter and packet status registers.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state     <= IDLE;
      bcnt      <= '0;
      pkt_done  <= 1'b0;
      pkt_beats <= '0;
      pkt_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      bcnt      <= bcnt_nxt;
      pkt_done  <= done_nxt;
      pkt_beats <= beats_nxt;
      pkt_err   <= err_nxt;
    end
  end

  // Skid FIFO: ping-pong storage with a registered occupancy count.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem_data[i] <= '0;
        mem_last[i] <= 1'b0;
        mem_user[i] <= '0;
        mem_id[i]   <= 1'b0;
        mem_dest[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= push_data;
        mem_last[wr_ptr] <= push_last;
        mem_user[wr_ptr] <= s_axis.S_TUSER;
        mem_id[wr_ptr]   <= s_axis.S_TID;
        mem_dest[wr_ptr] <= s_axis.S_TDEST;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_stream_receiver.sv
// Self-checking bench for axis_stream_receiver (MAX_BEATS=4).
// Directed scenarios plus a randomized run against a queue-based packet model.
module tb_axis_stream_receiver;
  localparam int DW   = 16;
  localparam int UW   = 2;
  localparam int DSTW = 8;
  localparam int MAXB = 4;
  localparam int CW   = $clog2(MAXB + 1);

  typedef struct packed {
    logic [DW-1:0]   data;
    logic            last;
    logic [UW-1:0]   user;
    logic            id;
    logic [DSTW-1:0] dest;
  } beat_t;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  axis_stream_receiver_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .DEST_WIDTH(DSTW)) s_axis ();

  logic            out_valid, out_ready, out_last, out_id, pkt_done, pkt_err;
  logic [DW-1:0]   out_data;
  logic [UW-1:0]   out_user;
  logic [DSTW-1:0] out_dest;
  logic [CW-1:0]   pkt_beats;
  logic [1:0]      rx_state;

  axis_stream_receiver #(
    .DATA_WIDTH(DW), .USER_WIDTH(UW), .DEST_WIDTH(DSTW), .MAX_BEATS(MAXB), .CNT_WIDTH(CW)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .s_axis(s_axis),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_user(out_user), .out_id(out_id), .out_dest(out_dest),
    .pkt_done(pkt_done), .pkt_beats(pkt_beats), .pkt_err(pkt_err), .rx_state(rx_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model
  beat_t         exp_q[$];
  int            m_cnt  = 0;
  bit            m_drop = 0;
  logic          m_done = 0;
  logic [CW-1:0] m_beats = '0;
  logic          m_err = 0;

  // pre-edge snapshots
  logic  exp_ready, exp_valid, pre_tready, pre_valid;
  beat_t exp_head, pre_head;

  function automatic logic [1:0] exp_state();
    if (m_drop) return 2'd2;
    if (m_cnt != 0) return 2'd1;
    return 2'd0;
  endfunction

  // One clock: drive at the falling edge, snapshot, advance the model at the rising edge.
  task automatic clk_cycle(input logic v, input logic [DW-1:0] d, input logic [1:0] k,
                           input logic l, input logic [UW-1:0] u, input logic i,
                           input logic [DSTW-1:0] de, input logic ordy);
    beat_t b;
    logic  acc, pop, nul;
    s_axis.S_TVALID = v;
    s_axis.S_TDATA  = d;
    s_axis.S_TKEEP  = k;
    s_axis.S_TLAST  = l;
    s_axis.S_TUSER  = u;
    s_axis.S_TID    = i;
    s_axis.S_TDEST  = de;
    out_ready       = ordy;
    exp_ready = ARESETn && (m_drop || exp_q.size() < 2);
    exp_valid = (exp_q.size() != 0);
    exp_head  = exp_valid ? exp_q[0] : '0;
    #1;
    pre_tready = s_axis.S_TREADY;
    pre_valid  = out_valid;
    pre_head   = {out_data, out_last, out_user, out_id, out_dest};
    acc = v && exp_ready;
    pop = exp_valid && ordy;
    @(posedge ACLK);
    m_done = 1'b0;
    if (!ARESETn) begin
      exp_q.delete();
      m_cnt = 0; m_drop = 0; m_beats = '0; m_err = 1'b0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) begin
        b.data = d; b.last = l; b.user = u; b.id = i; b.dest = de;
        nul = 1'b0;
`ifdef AXIS_RX_KEEP_MASK_EN
        for (int j = 0; j < DW / 8; j++) if (!k[j]) b.data[j*8 +: 8] = 8'h00;
        nul = (k == 2'b00);
`endif
        if (m_drop) begin
          if (l) begin m_done = 1; m_beats = CW'(MAXB); m_err = 1; m_drop = 0; m_cnt = 0; end
        end else if (nul) begin
          if (l) begin m_done = 1; m_beats = CW'(m_cnt); m_err = 1; m_cnt = 0; end
        end else begin
          m_cnt++;
          if (!l && m_cnt == MAXB) begin b.last = 1'b1; m_drop = 1; end
          exp_q.push_back(b);
          if (l) begin m_done = 1; m_beats = CW'(m_cnt); m_err = 0; m_cnt = 0; end
        end
      end
    end
    @(negedge ACLK);
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    clk_cycle(0, '0, 2'b11, 0, '0, 0, '0, 0);
    clk_cycle(1, 16'hFFFF, 2'b11, 1, '1, 1, '1, 1);
    n_checks++; if (s_axis.S_TREADY !== 1'b0) $display("FAIL reset_tready: got %b want 0", s_axis.S_TREADY); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if ({out_data, out_last, out_user, out_id, out_dest} !== '0) $display("FAIL reset_out_fields: got %h want 0", {out_data, out_last, out_user, out_id, out_dest}); else n_pass++;
    n_checks++; if ({pkt_done, pkt_beats, pkt_err, rx_state} !== '0) $display("FAIL reset_status: got %h want 0", {pkt_done, pkt_beats, pkt_err, rx_state}); else n_pass++;
    ARESETn = 1'b1;
    clk_cycle(0, '0, 2'b11, 0, '0, 0, '0, 1);
    n_checks++; if (s_axis.S_TREADY !== 1'b1) $display("FAIL release_tready: got %b want 1", s_axis.S_TREADY); else n_pass++;
  endtask

  task automatic test_basic_packet();
    logic [DW-1:0] d;
    for (int i = 0; i < 4; i++) begin
      d = 16'h1111 * DW'(i + 1);
      clk_cycle(1, d, 2'b11, (i == 3), UW'(i), i[0], DSTW'(8'h40 + i), 1);
      n_checks++; if (out_valid !== 1'b1 || out_data !== d) $display("FAIL basic_head[%0d]: got v=%b %h want v=1 %h", i, out_valid, out_data, d); else n_pass++;
      n_checks++; if (out_last !== (i == 3)) $display("FAIL basic_last[%0d]: got %b want %b", i, out_last, (i == 3)); else n_pass++;
      n_checks++; if (out_user !== UW'(i) || out_dest !== DSTW'(8'h40 + i)) $display("FAIL basic_side[%0d]: got %h/%h", i, out_user, out_dest); else n_pass++;
    end
    n_checks++; if ({pkt_done, pkt_beats, pkt_err} !== {1'b1, 3'd4, 1'b0}) $display("FAIL basic_status: got done=%b beats=%0d err=%b want 1/4/0", pkt_done, pkt_beats, pkt_err); else n_pass++;
    clk_cycle(0, '0, 2'b11, 0, '0, 0, '0, 1);
    n_checks++; if ({out_valid, pkt_done, pkt_beats} !== {1'b0, 1'b0, 3'd4}) $display("FAIL basic_after: got v=%b done=%b beats=%0d want 0/0/4", out_valid, pkt_done, pkt_beats); else n_pass++;
  endtask

  task automatic test_backpressure();
    clk_cycle(1, 16'hA001, 2'b11, 0, '0, 0, '0, 0);
    n_checks++; if (pre_tready !== 1'b1) $display("FAIL bp_ready0: got %b want 1", pre_tready); else n_pass++;
    clk_cycle(1, 16'hA002, 2'b11, 0, '0, 0, '0, 0);
    n_checks++; if (pre_tready !== 1'b1) $display("FAIL bp_ready1: got %b want 1", pre_tready); else n_pass++;
    clk_cycle(1, 16'hA003, 2'b11, 1, '0, 0, '0, 0);
    n_checks++; if (pre_tready !== 1'b0 || s_axis.S_TREADY !== 1'b0) $display("FAIL bp_full: got %b/%b want 0/0", pre_tready, s_axis.S_TREADY); else n_pass++;
    n_checks++; if (out_data !== 16'hA001) $display("FAIL bp_head0: got %h want a001", out_data); else n_pass++;
    clk_cycle(1, 16'hA003, 2'b11, 1, '0, 0, '0, 1);
    n_checks++; if (out_data !== 16'hA002 || s_axis.S_TREADY !== 1'b1) $display("FAIL bp_head1: got %h rdy=%b want a002 rdy=1", out_data, s_axis.S_TREADY); else n_pass++;
    clk_cycle(1, 16'hA003, 2'b11, 1, '0, 0, '0, 1);
    n_checks++; if (out_data !== 16'hA003 || out_last !== 1'b1) $display("FAIL bp_head2: got %h last=%b want a003 last=1", out_data, out_last); else n_pass++;
    n_checks++; if (pkt_done !== 1'b1 || pkt_beats !== 3'd3) $display("FAIL bp_status: got done=%b beats=%0d want 1/3", pkt_done, pkt_beats); else n_pass++;
    clk_cycle(0, '0, 2'b11, 0, '0, 0, '0, 1);
    n_checks++; if (out_valid !== 1'b0 || pkt_done !== 1'b0) $display("FAIL bp_drain: got v=%b done=%b want 0/0", out_valid, pkt_done); else n_pass++;
  endtask

  task automatic test_truncate();
    for (int i = 1; i <= 7; i++) begin
      clk_cycle(1, 16'h0100 + DW'(i), 2'b11, (i == 7), '0, 0, '0, 1);
      if (i <= 4) begin
        n_checks++; if (out_data !== 16'h0100 + DW'(i) || out_last !== (i == 4)) $display("FAIL trunc_head[%0d]: got %h last=%b", i, out_data, out_last); else n_pass++;
      end else begin
        n_checks++; if (pre_tready !== 1'b1 || out_valid !== 1'b0) $display("FAIL trunc_drop[%0d]: got rdy=%b v=%b want 1/0", i, pre_tready, out_valid); else n_pass++;
      end
      if (i == 4 || i == 6) begin
        n_checks++; if (rx_state !== 2'd2 || pkt_done !== 1'b0) $display("FAIL trunc_state[%0d]: got st=%0d done=%b want 2/0", i, rx_state, pkt_done); else n_pass++;
      end
    end
    n_checks++; if ({pkt_done, pkt_beats, pkt_err, rx_state} !== {1'b1, 3'd4, 1'b1, 2'd0}) $display("FAIL trunc_status: got done=%b beats=%0d err=%b st=%0d want 1/4/1/0", pkt_done, pkt_beats, pkt_err, rx_state); else n_pass++;
  endtask

  task automatic test_back_to_back();
    clk_cycle(1, 16'h0B01, 2'b11, 1, '0, 0, '0, 1);
    n_checks++; if ({pkt_done, pkt_beats, pkt_err, out_last} !== {1'b1, 3'd1, 1'b0, 1'b1}) $display("FAIL b2b_single: got done=%b beats=%0d err=%b last=%b want 1/1/0/1", pkt_done, pkt_beats, pkt_err, out_last); else n_pass++;
    clk_cycle(1, 16'h0B02, 2'b11, 0, '0, 0, '0, 1);
    n_checks++; if ({pkt_done, pkt_beats, rx_state} !== {1'b0, 3'd1, 2'd1}) $display("FAIL b2b_mid: got done=%b beats=%0d st=%0d want 0/1/1", pkt_done, pkt_beats, rx_state); else n_pass++;
    clk_cycle(1, 16'h0B03, 2'b11, 1, '0, 0, '0, 1);
    n_checks++; if ({pkt_done, pkt_beats, pkt_err} !== {1'b1, 3'd2, 1'b0}) $display("FAIL b2b_second: got done=%b beats=%0d err=%b want 1/2/0", pkt_done, pkt_beats, pkt_err); else n_pass++;
    clk_cycle(0, '0, 2'b11, 0, '0, 0, '0, 1);
  endtask

  task automatic test_reset_mid_packet();
    clk_cycle(1, 16'hC001, 2'b11, 0, '0, 0, '0, 0);
    clk_cycle(1, 16'hC002, 2'b11, 0, '0, 0, '0, 0);
    n_checks++; if (out_valid !== 1'b1 || rx_state !== 2'd1) $display("FAIL rmid_pre: got v=%b st=%0d want 1/1", out_valid, rx_state); else n_pass++;
    ARESETn = 1'b0;
    clk_cycle(1, 16'hC003, 2'b11, 1, '0, 0, '0, 0);
    n_checks++; if (pre_tready !== 1'b0) $display("FAIL rmid_ready_in_reset: got %b want 0", pre_tready); else n_pass++;
    n_checks++; if ({s_axis.S_TREADY, out_valid, rx_state, pkt_done, pkt_beats} !== '0) $display("FAIL rmid_cleared: got rdy=%b v=%b st=%0d done=%b beats=%0d want all 0", s_axis.S_TREADY, out_valid, rx_state, pkt_done, pkt_beats); else n_pass++;
    ARESETn = 1'b1;
    clk_cycle(1, 16'hD001, 2'b11, 0, '0, 0, '0, 1);
    n_checks++; if (out_data !== 16'hD001 || out_valid !== 1'b1) $display("FAIL rmid_new_head: got %h v=%b want d001 1", out_data, out_valid); else n_pass++;
    clk_cycle(1, 16'hD002, 2'b11, 1, '0, 0, '0, 1);
    n_checks++; if ({pkt_done, pkt_beats, pkt_err} !== {1'b1, 3'd2, 1'b0}) $display("FAIL rmid_recount: got done=%b beats=%0d err=%b want 1/2/0", pkt_done, pkt_beats, pkt_err); else n_pass++;
    clk_cycle(0, '0, 2'b11, 0, '0, 0, '0, 1);
  endtask

`ifdef AXIS_RX_KEEP_MASK_EN
  task automatic test_keep_mask();
    clk_cycle(1, 16'hABCD, 2'b01, 0, '0, 0, '0, 0);
    n_checks++; if (out_data !== 16'h00CD) $display("FAIL keep_mask: got %h want 00cd", out_data); else n_pass++;
    clk_cycle(1, 16'h5555, 2'b00, 0, '0, 0, '0, 1);
    n_checks++; if (out_valid !== 1'b0 || rx_state !== 2'd1) $display("FAIL keep_null: got v=%b st=%0d want 0/1", out_valid, rx_state); else n_pass++;
    clk_cycle(1, 16'h1234, 2'b11, 1, '0, 0, '0, 1);
    n_checks++; if ({pkt_done, pkt_beats, pkt_err, out_data} !== {1'b1, 3'd2, 1'b0, 16'h1234}) $display("FAIL keep_count: got done=%b beats=%0d err=%b data=%h want 1/2/0/1234", pkt_done, pkt_beats, pkt_err, out_data); else n_pass++;
    clk_cycle(0, '0, 2'b11, 0, '0, 0, '0, 1);
  endtask
`endif

  task automatic test_random();
    logic v, l, ordy;
    for (int n = 0; n < 1500; n++) begin
      v    = ($urandom_range(0, 3) != 0);
      l    = ($urandom_range(0, 3) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      clk_cycle(v, DW'($urandom), 2'($urandom), l, UW'($urandom), 1'($urandom),
                DSTW'($urandom), ordy);
      n_checks++; if (pre_tready !== exp_ready) $display("FAIL rnd_tready[%0d]: got %b want %b", n, pre_tready, exp_ready); else n_pass++;
      n_checks++; if (pre_valid !== exp_valid) $display("FAIL rnd_valid[%0d]: got %b want %b", n, pre_valid, exp_valid); else n_pass++;
      if (exp_valid) begin
        n_checks++; if (pre_head !== exp_head) $display("FAIL rnd_head[%0d]: got %h want %h", n, pre_head, exp_head); else n_pass++;
      end
      n_checks++; if (pkt_done !== m_done) $display("FAIL rnd_done[%0d]: got %b want %b", n, pkt_done, m_done); else n_pass++;
      n_checks++; if (pkt_beats !== m_beats || pkt_err !== m_err) $display("FAIL rnd_status[%0d]: got %0d/%b want %0d/%b", n, pkt_beats, pkt_err, m_beats, m_err); else n_pass++;
      n_checks++; if (rx_state !== exp_state()) $display("FAIL rnd_state[%0d]: got %0d want %0d", n, rx_state, exp_state()); else n_pass++;
    end
  endtask

  initial begin
    s_axis.S_TVALID = 1'b0;
    s_axis.S_TDATA  = '0;
    s_axis.S_TKEEP  = 2'b11;
    s_axis.S_TLAST  = 1'b0;
    s_axis.S_TUSER  = '0;
    s_axis.S_TID    = 1'b0;
    s_axis.S_TDEST  = '0;
    out_ready       = 1'b0;
    @(negedge ACLK);
    test_reset();
    test_basic_packet();
    test_backpressure();
    test_truncate();
    test_back_to_back();
`ifdef AXIS_RX_KEEP_MASK_EN
    test_keep_mask();
`endif
    test_reset_mid_packet();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/axis_stream_receiver.md
Name: axis_stream_receiver

Overview:
AXI-Stream slave endpoint that terminates a stream from an upstream AXI-Stream transmitter. Incoming beats go into a 2-entry skid FIFO and are presented on a simple valid/ready output port to downstream logic, such as the SHA3 absorb datapath. A packet framer counts beats per packet, truncates oversize packets to MAX_BEATS, and reports per-packet status.

Parameters:
DATA_WIDTH, 16, TDATA width in bits; must be a multiple of 8.
USER_WIDTH, 2, TUSER width.
DEST_WIDTH, 8, TDEST width.
MAX_BEATS, 256, maximum beats forwarded per packet.
CNT_WIDTH, $clog2(MAX_BEATS+1), width of the beat counter.

Ports:
ACLK  in  1  clock
ARESETn  in  1  synchronous active-low reset
S_TVALID  in  1  upstream beat valid
S_TREADY  out  1  receiver can accept a beat
S_TDATA  in  DATA_WIDTH  beat data
S_TKEEP  in  DATA_WIDTH/8  byte qualifiers
S_TLAST  in  1  last beat of packet
S_TUSER  in  USER_WIDTH  user sideband
S_TID  in  1  stream ID
S_TDEST  in  DEST_WIDTH  routing destination
out_valid  out  1  FIFO head valid
out_ready  in  1  downstream pops the head
out_data  out  DATA_WIDTH  head data
out_last  out  1  head is the last beat of its (possibly truncated) packet
out_user  out  USER_WIDTH  head TUSER
out_id  out  1  head TID
out_dest  out  DEST_WIDTH  head TDEST
pkt_done  out  1  one-cycle pulse when a packet ends
pkt_beats  out  CNT_WIDTH  beats forwarded for the last completed packet; held
pkt_err  out  1  last completed packet was truncated; held
rx_state  out  2  FSM state, for debug

Behaviour:
- Reset: ARESETn is synchronous and active-low; clock is ACLK. While ARESETn=0 and on the first edge with ARESETn=0:
  - All outputs go to 0, including S_TREADY=0.
  - FIFO is emptied, beat counter cleared, FSM enters IDLE.
  - Reset mid-packet discards all buffered beats; there is no out_last for the aborted packet.
- Accept rule: a beat is accepted on an edge where S_TVALID && S_TREADY.
- Pop rule: the head is popped on an edge where out_valid && out_ready.
- FIFO:
  - 2 entries, registered occupancy count 0..2.
  - S_TREADY = (count<2) in IDLE/IN_PKT; S_TREADY = 1 in DROP. S_TREADY is 0 while in reset.
  - out_valid = (count!=0); out_* always reflect the head entry.
  - Latency: a beat accepted at edge N is visible on out_* after edge N if the FIFO was empty.
  - Simultaneous push and pop at count 1: count stays 1 and the new beat becomes the head next cycle.
  - Push at count 2 is impossible because S_TREADY=0. Pop at count 0 is ignored.
  - Throughput is one beat per cycle when out_ready is held 1.
- FSM states: IDLE=0, IN_PKT=1, DROP=2; code 3 is illegal and returns to IDLE.
  - Beat counter bcnt holds beats forwarded in the current packet.
  - IDLE, accepted beat with S_TLAST=1: push it, pkt_done pulse, pkt_beats=1, pkt_err=0, stay IDLE.
  - IDLE, accepted beat with S_TLAST=0: push it, bcnt=1, go to IN_PKT.
  - IN_PKT, accepted beat: push it, bcnt+1.
    - If S_TLAST=1: pkt_done, pkt_beats=bcnt+1, pkt_err=0, go to IDLE.
    - Else if bcnt+1==MAX_BEATS: the pushed entry gets out_last forced to 1; go to DROP.
  - MAX_BEATS==1 in IDLE: the non-last beat is pushed with forced last, and the FSM goes to DROP.
  - DROP: accepted beats are discarded and never pushed.
    - On an accepted S_TLAST beat: pkt_done, pkt_beats=MAX_BEATS, pkt_err=1, go to IDLE.
- Status timing:
  - pkt_done asserts on the cycle after the edge that accepted the terminating beat.
  - pkt_beats and pkt_err update on that same edge and hold until the next pkt_done.
- Sideband: TUSER, TID and TDEST are stored per beat. A mid-packet change is forwarded as-is with no error.
- Without the optional feature, TKEEP is ignored.

Optional Feature:
Macro AXIS_RX_KEEP_MASK_EN.
- Defined: each stored byte lane whose S_TKEEP bit is 0 is zeroed in out_data. A beat with S_TKEEP all zero (null beat) is accepted but not pushed or counted. A null beat carrying S_TLAST still terminates the packet (pkt_done, pkt_beats=bcnt); out_last is then lost for that packet and pkt_err is set to 1.
- Undefined: S_TKEEP is unused and data passes unmodified.

Test Plan:
- Reset release, then a 4-beat packet 0x1111..0x4444 with out_ready=1 -> out_* shows each beat one cycle after acceptance, out_last only on 0x4444, pkt_done pulse, pkt_beats=4, pkt_err=0.
- out_ready=0 with S_TVALID held -> 2 beats accepted, then S_TREADY=0. Raise out_ready -> beats emerge in order with no loss or duplication, and S_TREADY returns to 1.
- MAX_BEATS=4, send a 7-beat packet -> 4 beats out with out_last on beat 4; beats 5-7 accepted with S_TREADY=1 and dropped; pkt_done with pkt_beats=4, pkt_err=1.
- Single-beat packet (S_TLAST=1) in IDLE, then immediately a 2-beat packet -> pkt_beats=1 then 2, with two pkt_done pulses.
- Assert ARESETn=0 mid-packet with 2 beats buffered -> S_TREADY=0, out_valid=0, rx_state=0 on the next cycle, no pkt_done; the next packet is counted from 1.
- With AXIS_RX_KEEP_MASK_EN defined, S_TKEEP=2'b01, S_TDATA=0xABCD -> out_data=0x00CD. S_TKEEP=2'b00 non-last -> beat not forwarded and not counted.
